// File: rtl/rs_cmd_pkg.sv
// rs_cmd_pkg: shared FSM state type, default timing constants and counter width helper.
package rs_cmd_pkg;
  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rs_debounce.sv
// rs_debounce: optional 2-flop synchronizer (RS_CMD_SYNC_EN), stable-level debouncer and registered rise pulse.
module rs_debounce
  import rs_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic smp;
`ifdef RS_CMD_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], btn_i};
  assign smp = sync_q[1];
`else
  assign smp = btn_i;
`endif
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, hit;
  // The last differing sample flips the level, so D differing samples in a row are required.
  always_comb begin
    hit = (smp != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (smp == level_q || hit) ? '0 : cnt_q + CW'(1);
    level_d = hit ? smp : level_q;
    rise_d = hit & smp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
    end
  assign rise_o = rise_q;
endmodule

// File: rtl/rs_cmd_debounce.sv
// rs_cmd_debounce: debounced button-to-command stage for the NAND RS latch; set/rst never overlap.
// Define RS_CMD_SYNC_EN to add a 2-flop synchronizer per button input.
module rs_cmd_debounce
  import rs_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic rst_btn,
  output logic set,
  output logic rst,
  output logic busy
);
  localparam int PW = cnt_w(PULSE_LEN);
  logic set_rise, rst_rise, set_req, rst_req;
  logic set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  state_e state_q, state_d;
  rs_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .rst_n(reset), .btn_i(set_btn), .rise_o(set_rise)
  );
  rs_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clk(clk), .rst_n(reset), .btn_i(rst_btn), .rise_o(rst_rise)
  );
  // A fresh rise is served in the same IDLE cycle; otherwise it parks in its 1-deep flag.
  always_comb begin
    state_d = state_q;
    pcnt_d = '0;
    set_req = set_pend_q | set_rise;
    rst_req = rst_pend_q | rst_rise;
    set_pend_d = set_req;
    rst_pend_d = rst_req;
    case (state_q)
      IDLE:
        if (rst_req) begin
          state_d = RST_P;
          rst_pend_d = 1'b0;
        end else if (set_req) begin
          state_d = SET_P;
          set_pend_d = 1'b0;
        end
      SET_P, RST_P: begin
        pcnt_d = pcnt_q + PW'(1);
        if (pcnt_q == PW'(PULSE_LEN - 1)) begin
          state_d = GAP;
          pcnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
    end
  assign set = state_q == SET_P;
  assign rst = state_q == RST_P;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_rs_cmd_debounce.sv
// tb_rs_cmd_debounce: scoreboard bench; expected command starts are queued at stimulus time.
module tb_rs_cmd_debounce;
  localparam int D = 4;
  localparam int P = 2;
`ifdef RS_CMD_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif
  typedef struct {bit is_rst; int at;} exp_t;
  exp_t exp_q[$];
  logic clk = 0, reset = 0, set_btn = 0, rst_btn = 0;
  logic set, rst, busy;
  int cyc = 0, checks = 0, errors = 0, start = 0;
  logic pset = 0, prst = 0;

  rs_cmd_debounce #(.DEBOUNCE_CYCLES(D), .PULSE_LEN(P)) dut (
    .clk(clk), .reset(reset), .set_btn(set_btn), .rst_btn(rst_btn),
    .set(set), .rst(rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push(input bit r, input int at);
    exp_t e;
    e.is_rst = r;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    if (set && rst) begin
      errors++;
      $display("FAIL overlap cyc=%0d set=%b rst=%b required not both 1", cyc, set, rst);
    end
    if ((set && !pset) || (rst && !prst)) begin
      start = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd cyc=%0d rst=%b required no command", cyc, rst);
      end else begin
        e = exp_q.pop_front();
        if (rst !== e.is_rst || cyc != e.at) begin
          errors++;
          $display("FAIL cmd_start got rst=%b at %0d required rst=%b at %0d", rst, cyc, e.is_rst, e.at);
        end
      end
    end
    if ((pset && !set) || (prst && !rst)) begin
      checks++;
      if (cyc - start != P) begin
        errors++;
        $display("FAIL pulse_len got %0d required %0d", cyc - start, P);
      end
    end
    if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
      errors++;
      $display("FAIL missing_cmd rst=%b required at %0d, none by %0d", exp_q[0].is_rst, exp_q[0].at, cyc);
      void'(exp_q.pop_front());
    end
    pset = set;
    prst = rst;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 0;
    #1;
    checks += 3;
    if (set !== 1'b0) begin errors++; $display("FAIL reset_set got %b required 0", set); end
    if (rst !== 1'b0) begin errors++; $display("FAIL reset_rst got %b required 0", rst); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    wait_n(2);
    reset = 1;
    wait_n(3);
  endtask

  task automatic test_clean();
    int k;
    k = cyc + 1;
    set_btn = 1;
    push(0, k + LAT);
    repeat (LAT + P + 4) begin
      tick();
      checks++;
      if (busy !== logic'(cyc >= k + LAT && cyc <= k + LAT + P)) begin
        errors++;
        $display("FAIL clean_busy cyc=%0d got %b required %b", cyc, busy, cyc >= k + LAT && cyc <= k + LAT + P);
      end
    end
    set_btn = 0;
    wait_n(15);
  endtask

  task automatic test_bounce();
    int k;
    set_btn = 1;
    wait_n(3);
    set_btn = 0;
    tick();
    k = cyc + 1;
    set_btn = 1;
    push(0, k + LAT);
    wait_n(LAT + P + 6);
    set_btn = 0;
    wait_n(15);
  endtask

  task automatic test_simul();
    int k;
    k = cyc + 1;
    set_btn = 1;
    rst_btn = 1;
    push(1, k + LAT);
    push(0, k + LAT + P + 2);
    wait_n(LAT + 2 * P + 8);
    set_btn = 0;
    rst_btn = 0;
    wait_n(15);
  endtask

  task automatic test_queued();
    int k;
    k = cyc + 1;
    set_btn = 1;
    tick();
    rst_btn = 1;
    push(0, k + LAT);
    push(1, k + LAT + P + 2);
    wait_n(LAT + 2 * P + 8);
    set_btn = 0;
    rst_btn = 0;
    wait_n(15);
  endtask

  task automatic test_midreset();
    int k;
    k = cyc + 1;
    set_btn = 1;
    push(0, k + LAT);
    wait_n(LAT + 2);
    checks++;
    if (set !== 1'b1) begin errors++; $display("FAIL mid_set_before got %b required 1", set); end
    reset = 0;
    #1;
    checks += 3;
    if (set !== 1'b0) begin errors++; $display("FAIL mid_set_async got %b required 0", set); end
    if (rst !== 1'b0) begin errors++; $display("FAIL mid_rst_async got %b required 0", rst); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b required 0", busy); end
    pset = 0;
    prst = 0;
    set_btn = 0;
    wait_n(2);
    reset = 1;
    wait_n(30);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy got %b required 0", busy); end
  endtask

  task automatic test_hold_reset();
    int k;
    set_btn = 1;
    tick();
    reset = 0;
    wait_n(2);
    reset = 1;
    k = cyc + 1;
    push(0, k + LAT);
    wait_n(LAT + P + 6);
    set_btn = 0;
    wait_n(15);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_simul();
    test_queued();
    test_midreset();
    test_hold_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
